// File: rtl/watch_pkg.sv
// Shared encoding, defaults and state helpers for the watch controller.
package watch_pkg;

    localparam int STATE_W              = 4;
    localparam int DEF_DEBOUNCE_CYCLES  = 4;
    localparam int DEF_HOLD_CYCLES      = 16;
    localparam int DEF_REPEAT_CYCLES    = 4;
    localparam bit DEF_ALARM_EN         = 1'b1;

    localparam int NUM_BTN  = 4;
    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;
    localparam int BTN_DEC  = 2;
    localparam int BTN_SET  = 3;

    typedef enum logic [STATE_W-1:0] {
        SW_HIDE_STOPPED = 4'd0,
        SW_SHOW_STOPPED = 4'd1,
        SW_SHOW_RUNNING = 4'd2,
        SW_HIDE_RUNNING = 4'd3,
        SW_RESET        = 4'd4,
        SET_H           = 4'd5,
        SET_M           = 4'd6,
        ALM_H           = 4'd7,
        ALM_M           = 4'd8
    } state_t;

    typedef struct packed {
        logic level;
        logic press;
        logic rpt;
    } btn_evt_t;

    function automatic logic is_sw(input state_t s);
        return (s == SW_HIDE_STOPPED) || (s == SW_SHOW_STOPPED) ||
               (s == SW_SHOW_RUNNING) || (s == SW_HIDE_RUNNING) || (s == SW_RESET);
    endfunction

    // SW_RESET is transient, so it is remembered as the stopped view it returns to.
    function automatic state_t save_map(input state_t s);
        return (s == SW_RESET) ? SW_SHOW_STOPPED : s;
    endfunction

    function automatic state_t swap_view(input state_t s);
        case (s)
            SW_HIDE_STOPPED: return SW_SHOW_STOPPED;
            SW_SHOW_STOPPED: return SW_HIDE_STOPPED;
            SW_HIDE_RUNNING: return SW_SHOW_RUNNING;
            SW_SHOW_RUNNING: return SW_HIDE_RUNNING;
            default:         return s;
        endcase
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-FF sync, debounce, press edge, optional hold/auto-repeat.
module btn_cond
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     raw,
    input  logic     hold_clr,
    output btn_evt_t evt
);

    logic [1:0] sync;
    logic [7:0] db_cnt;
    logic       deb;
    logic       deb_d;
    logic [9:0] hold_cnt;
    logic       in_rpt;
    logic       rpt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= 2'b00;
            db_cnt <= 8'd0;
            deb    <= 1'b0;
            deb_d  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            deb_d <= deb;
            if (sync[1] == deb) begin
                db_cnt <= 8'd0;
            end else if (db_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
                deb    <= sync[1];
                db_cnt <= 8'd0;
            end else begin
                db_cnt <= db_cnt + 8'd1;
            end
        end
    end

    // hold_cnt equals the number of cycles since the press (or since the last repeat).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= 10'd0;
            in_rpt   <= 1'b0;
        end else if (!REPEAT_EN || !deb || hold_clr) begin
            hold_cnt <= 10'd0;
            in_rpt   <= 1'b0;
        end else if (rpt) begin
            hold_cnt <= 10'd1;
            in_rpt   <= 1'b1;
        end else begin
            hold_cnt <= hold_cnt + 10'd1;
        end
    end

    assign rpt = REPEAT_EN && deb &&
                 (in_rpt ? (hold_cnt == 10'(REPEAT_CYCLES)) : (hold_cnt == 10'(HOLD_CYCLES)));

    assign evt.level = deb;
    assign evt.press = deb & ~deb_d;
    assign evt.rpt   = rpt;

endmodule

// File: rtl/watch_ctrl_gen2.sv
// Watch mode controller: stopwatch views, time/alarm set states, adjust pulses.
module watch_ctrl_gen2
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit ALARM_EN        = DEF_ALARM_EN
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_mode,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic               btn_set,
    output logic [STATE_W-1:0] state,
    output logic               run_stopwatch,
    output logic               reset_stopwatch,
    output logic               run_time,
    output logic               inc_h,
    output logic               dec_h,
    output logic               inc_m,
    output logic               dec_m,
    output logic               alarm_sel,
    output logic               alarm_on
);

    logic     [NUM_BTN-1:0] raw;
    btn_evt_t [NUM_BTN-1:0] evt;
    logic                   both;
    logic                   unused_evt;

    state_t state_q, nxt_state;
    state_t saved_q, nxt_saved;
    logic   run_q, nxt_run;
    logic   alarm_q, nxt_alarm;
    logic   pulse_inc, pulse_dec;
    logic   fld_h;

    assign raw[BTN_MODE] = btn_mode;
    assign raw[BTN_INC]  = btn_inc;
    assign raw[BTN_DEC]  = btn_dec;
    assign raw[BTN_SET]  = btn_set;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_cond #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .REPEAT_EN      ((i == BTN_INC) || (i == BTN_DEC))
        ) u_btn (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (raw[i]),
            .hold_clr(both),
            .evt     (evt[i])
        );
    end

    assign unused_evt = ^{evt[BTN_MODE].level, evt[BTN_MODE].rpt,
                          evt[BTN_SET].level,  evt[BTN_SET].rpt};

    // inc and dec held together cancel each other and restart the hold timing.
    assign both  = evt[BTN_INC].level & evt[BTN_DEC].level;
    assign fld_h = (state_q == SET_H) || (state_q == ALM_H);

    always_comb begin
        nxt_state = state_q;
        nxt_saved = saved_q;
        nxt_run   = run_q;
        nxt_alarm = alarm_q;
        pulse_inc = 1'b0;
        pulse_dec = 1'b0;
        if (evt[BTN_SET].press) begin
            case (state_q)
                SET_H:   nxt_state = SET_M;
                SET_M:   nxt_state = ALARM_EN ? ALM_H : saved_q;
                ALM_H:   nxt_state = ALM_M;
                ALM_M:   nxt_state = saved_q;
                default: begin
                    nxt_saved = save_map(state_q);
                    nxt_state = SET_H;
                end
            endcase
        end else if (evt[BTN_MODE].press) begin
            nxt_state = is_sw(state_q) ? swap_view(save_map(state_q)) : saved_q;
        end else if (state_q == SW_RESET) begin
            nxt_state = SW_SHOW_STOPPED;
        end else if (!both) begin
            case (state_q)
                SW_SHOW_STOPPED: begin
                    if (evt[BTN_INC].press) begin
                        nxt_state = SW_SHOW_RUNNING;
                        nxt_run   = 1'b1;
                    end else if (evt[BTN_DEC].press) begin
                        nxt_state = SW_RESET;
                    end
                end
                SW_SHOW_RUNNING: begin
                    if (evt[BTN_INC].press) begin
                        nxt_state = SW_SHOW_STOPPED;
                        nxt_run   = 1'b0;
                    end
                end
                SW_HIDE_STOPPED, SW_HIDE_RUNNING: begin
                    if (ALARM_EN && evt[BTN_INC].press) nxt_alarm = ~alarm_q;
                end
                default: begin
                    pulse_inc = evt[BTN_INC].press | evt[BTN_INC].rpt;
                    pulse_dec = evt[BTN_DEC].press | evt[BTN_DEC].rpt;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= SW_HIDE_STOPPED;
            saved_q         <= SW_HIDE_STOPPED;
            run_q           <= 1'b0;
            alarm_q         <= 1'b0;
            reset_stopwatch <= 1'b0;
            run_time        <= 1'b1;
            alarm_sel       <= 1'b0;
            inc_h           <= 1'b0;
            dec_h           <= 1'b0;
            inc_m           <= 1'b0;
            dec_m           <= 1'b0;
        end else begin
            state_q         <= nxt_state;
            saved_q         <= nxt_saved;
            run_q           <= nxt_run;
            alarm_q         <= nxt_alarm;
            reset_stopwatch <= (nxt_state == SW_RESET);
            run_time        <= !((nxt_state == SET_H) || (nxt_state == SET_M));
            alarm_sel       <= (nxt_state == ALM_H) || (nxt_state == ALM_M);
            inc_h           <= pulse_inc &  fld_h;
            dec_h           <= pulse_dec &  fld_h;
            inc_m           <= pulse_inc & ~fld_h;
            dec_m           <= pulse_dec & ~fld_h;
        end
    end

    assign state         = state_q;
    assign run_stopwatch = run_q;
    assign alarm_on      = alarm_q;

endmodule

// File: tb/tb_watch_ctrl_gen2.sv
// Scoreboard bench: abstract watch model predicts every output change and its cycle.
module tb_watch_ctrl_gen2;
    import watch_pkg::*;

    localparam int D = 2;
    localparam int H = 8;
    localparam int R = 3;
    localparam logic [3:0] M_MODE = 4'b0001;
    localparam logic [3:0] M_INC  = 4'b0010;
    localparam logic [3:0] M_DEC  = 4'b0100;
    localparam logic [3:0] M_SET  = 4'b1000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_set = 1'b0;
    logic [3:0] state;
    logic       run_stopwatch, reset_stopwatch, run_time;
    logic       inc_h, dec_h, inc_m, dec_m, alarm_sel, alarm_on;

    watch_ctrl_gen2 #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .ALARM_EN(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_set(btn_set),
        .state(state), .run_stopwatch(run_stopwatch), .reset_stopwatch(reset_stopwatch),
        .run_time(run_time), .inc_h(inc_h), .dec_h(dec_h), .inc_m(inc_m), .dec_m(dec_m),
        .alarm_sel(alarm_sel), .alarm_on(alarm_on)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [12:0] outs;
    assign outs = {state, run_stopwatch, reset_stopwatch, run_time,
                   inc_h, dec_h, inc_m, dec_m, alarm_sel, alarm_on};

    typedef struct {
        logic [12:0] v;
        int          t;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    // Model: md 0=stopwatch 1=set hours 2=set minutes 3=alarm hours 4=alarm minutes.
    int          md;
    bit          show, run_m, alarm_m, saved_show;
    logic [12:0] last_v;
    logic [12:0] rst_v;

    function automatic logic [12:0] snap(input logic [3:0] st, input logic rn, rs, rt,
                                         ih, dh, im, dm, as, ao);
        return {st, rn, rs, rt, ih, dh, im, dm, as, ao};
    endfunction

    function automatic logic [3:0] mcode();
        case (md)
            1: return SET_H;
            2: return SET_M;
            3: return ALM_H;
            4: return ALM_M;
            default:
                if (show) return run_m ? SW_SHOW_RUNNING : SW_SHOW_STOPPED;
                else      return run_m ? SW_HIDE_RUNNING : SW_HIDE_STOPPED;
        endcase
    endfunction

    function automatic logic [12:0] mvec(input logic rs, ih, dh, im, dm);
        return snap(rs ? 4'(SW_RESET) : mcode(), run_m, rs, !(md == 1 || md == 2),
                    ih, dh, im, dm, md >= 3, alarm_m);
    endfunction

    task automatic push(input logic [12:0] v, input int t);
        if (v !== last_v) begin
            q.push_back('{v, t});
            last_v = v;
        end
    endtask

    task automatic m_reset();
        md = 0; show = 0; run_m = 0; alarm_m = 0; saved_show = 0;
        last_v = rst_v;
    endtask

    // A press registered at drive cycle c0 shows up at c0+D+3; raw high for len cycles
    // keeps the debounced level high for len cycles, so repeats fire at H, H+R, ... < len.
    task automatic m_press(input logic [3:0] mask, input int c0, input int len);
        int  t;
        bit  fh;
        if (len < D) return;
        t = c0 + D + 3;
        if (mask[3]) begin
            case (md)
                0:       begin saved_show = show; md = 1; end
                1:       md = 2;
                2:       md = 3;
                3:       md = 4;
                default: begin md = 0; show = saved_show; end
            endcase
            push(mvec(0, 0, 0, 0, 0), t);
        end else if (mask[0]) begin
            if (md == 0) show = !show;
            else begin md = 0; show = saved_show; end
            push(mvec(0, 0, 0, 0, 0), t);
        end else if (mask[1] && mask[2]) begin
            // cancelled
        end else if (mask[1] || mask[2]) begin
            if (md == 0) begin
                if (mask[1]) begin
                    if (show) run_m = !run_m;
                    else      alarm_m = !alarm_m;
                    push(mvec(0, 0, 0, 0, 0), t);
                end else if (show && !run_m) begin
                    push(mvec(1, 0, 0, 0, 0), t);
                    push(mvec(0, 0, 0, 0, 0), t + 1);
                end
            end else begin
                fh = (md == 1) || (md == 3);
                for (int k = 0; k < len; k = (k == 0) ? H : k + R) begin
                    push(mvec(0, mask[1] & fh, mask[2] & fh, mask[1] & !fh, mask[2] & !fh), t + k);
                    push(mvec(0, 0, 0, 0, 0), t + k + 1);
                end
            end
        end
    endtask

    task automatic drive(input logic [3:0] mask);
        {btn_set, btn_dec, btn_inc, btn_mode} = mask;
    endtask

    task automatic press(input logic [3:0] mask, input int len, input int gap);
        int c0;
        @(negedge clk);
        c0 = cyc;
        drive(mask);
        m_press(mask, c0, len);
        repeat (len) @(negedge clk);
        drive(4'b0000);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_rst(input string name);
        n_cmp++;
        if (outs !== rst_v) begin
            n_bad++;
            $display("FAIL %s got=%h required=%h", name, outs, rst_v);
        end
    endtask

    logic [12:0] prev = '0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && outs !== prev) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change cyc=%0d got=%h required=%h", cyc, outs, prev);
            end else begin
                e = q.pop_front();
                if (outs !== e.v || cyc != e.t) begin
                    n_bad++;
                    $display("FAIL out_change got=%h@%0d required=%h@%0d", outs, cyc, e.v, e.t);
                end
            end
        end
        prev = outs;
    end

    initial begin
        int c0;
        int r, len;
        logic [3:0] mask;
        rst_v = snap(SW_HIDE_STOPPED, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        #3 reset_n = 1'b0;
        #1 check_rst("reset_async");
        m_reset();
        repeat (3) @(negedge clk);
        check_rst("reset_held");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (2) @(negedge clk);

        // stopwatch views and run toggling
        press(M_MODE, 4, 8);
        press(M_INC, 4, 8);
        press(M_INC, 4, 8);
        press(M_DEC, 4, 8);
        press(M_INC, 4, 8);
        press(M_MODE, 4, 8);
        // full set chain from a running hidden view, with auto-repeat in SET_M
        press(M_SET, 4, 8);
        press(M_SET, 4, 8);
        press(M_INC, 20, 10);
        press(M_SET, 4, 8);
        press(M_SET, 4, 8);
        press(M_SET, 4, 8);
        // inc+dec together cancels, mode aborts
        press(M_SET, 4, 8);
        press(M_INC | M_DEC, 14, 8);
        press(M_MODE, 4, 8);
        // glitch shorter than the debounce window, then alarm toggle from a hidden view
        press(M_MODE, 1, 8);
        press(M_INC, 4, 8);
        press(M_DEC, 4, 8);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      mask = M_MODE;
            else if (r < 5) mask = M_INC;
            else if (r < 7) mask = M_DEC;
            else if (r < 9) mask = M_SET;
            else            mask = M_INC | M_DEC;
            len = $urandom_range(1, 24);
            press(mask, len, D + 6 + $urandom_range(0, 5));
        end

        // reset in the middle of an auto-repeat, with mode held through release
        press(M_MODE, 4, 8);
        press(M_SET, 4, 8);
        press(M_SET, 4, 8);
        @(negedge clk);
        c0 = cyc;
        drive(M_DEC);
        m_press(M_DEC, c0, 40);
        repeat (17) @(negedge clk);
        @(posedge clk);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        drive(M_MODE);
        #1 check_rst("reset_mid_repeat");
        q.delete();
        m_reset();
        repeat (3) @(negedge clk);
        c0 = cyc;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        m_press(M_MODE, c0, 6);
        repeat (6) @(negedge clk);
        drive(4'b0000);
        repeat (30) @(negedge clk);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_expected got=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/watch_ctrl_gen2.md
WATCH_CTRL_GEN2 -- requirements
Module: watch_ctrl_gen2

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: cycles a synchronised button level must stay stable before the debounced level follows; range 1..255.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles a debounced inc/dec press is held in a set state before auto-repeat starts; range 2..1023.
REQ-003 Parameter REPEAT_CYCLES, default 4: auto-repeat pulse period in cycles; range 1..255.
REQ-004 Parameter ALARM_EN, default 1: 1 adds alarm-set states; 0 removes them.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 btn_mode, btn_inc, btn_dec, btn_set  in  1 each  raw asynchronous buttons, active-high.
REQ-008 state  out  4  current state encoding from the package.
REQ-009 run_stopwatch, reset_stopwatch, run_time  out  1 each  stopwatch run level, stopwatch clear pulse, and timekeeping enable.
REQ-010 inc_h, dec_h, inc_m, dec_m  out  1 each  single-cycle adjust pulses.
REQ-011 alarm_sel  out  1  adjust pulses target the alarm registers, not the time registers.
REQ-012 alarm_on  out  1  alarm armed level.

Function
REQ-013 Each button SHALL pass through a 2-FF synchroniser, then a debounce counter, then a rising-edge detector that produces a one-cycle press event.
REQ-014 The registered response (state or output) to a clean raw press SHALL appear exactly DEBOUNCE_CYCLES+3 rising edges after the raw level is first sampled high.
REQ-015 States SHALL be SW_HIDE_STOPPED, SW_SHOW_STOPPED, SW_SHOW_RUNNING, SW_HIDE_RUNNING, SW_RESET, SET_H, SET_M, ALM_H and ALM_M; the ALM states exist only when ALARM_EN=1.
REQ-016 A mode press SHALL swap between HIDE and SHOW while the stopwatch run status is kept.
REQ-017 An inc press in a SHOW state SHALL toggle between SHOW_STOPPED and SHOW_RUNNING.
REQ-018 An inc press in a HIDE state SHALL toggle alarm_on when ALARM_EN=1 and SHALL be ignored when ALARM_EN=0.
REQ-019 A dec press in SW_SHOW_STOPPED SHALL enter SW_RESET for exactly one cycle and then return to SW_SHOW_STOPPED; dec is ignored in every other stopwatch state.
REQ-020 A set press in any stopwatch state SHALL save that state and enter SET_H.
REQ-021 From SET_H, a set press SHALL go to SET_M.
REQ-022 From SET_M, a set press SHALL go to ALM_H, or to the saved state when ALARM_EN=0.
REQ-023 From ALM_H, a set press SHALL go to ALM_M; from ALM_M, a set press SHALL go to the saved state.
REQ-024 A mode press in any set or alarm state SHALL abort to the saved state.
REQ-025 The saved state SHALL be SW_HIDE_* or SW_SHOW_*, using the current value of run_stopwatch; SW_RESET is never saved and maps to SW_SHOW_STOPPED.
REQ-026 In set and alarm states, an inc or dec press SHALL emit one pulse on the field's inc or dec output.
REQ-027 While the same button stays held, it SHALL emit a further pulse after HOLD_CYCLES cycles and then one pulse every REPEAT_CYCLES cycles until release.
REQ-028 When inc and dec are both debounced-high, the block SHALL emit no pulse and SHALL reset the hold counter.
REQ-029 When several press events occur in the same cycle, priority SHALL be set > mode > inc/dec, and only one event SHALL be acted on per cycle.
REQ-030 run_time SHALL be 0 in SET_H and SET_M, and 1 otherwise.
REQ-031 run_stopwatch SHALL be the stopwatch run register, which keeps running through set and alarm states.
REQ-032 reset_stopwatch SHALL be 1 only in SW_RESET.
REQ-033 alarm_sel SHALL be 1 only in ALM_H and ALM_M.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 Asserting reset_n low SHALL, immediately and regardless of clk, set state to SW_HIDE_STOPPED, run_stopwatch=0, run_time=1, and every other output to 0.
REQ-036 The same reset SHALL clear the synchronisers, the debounce and hold counters, and the saved state.
REQ-037 Reset asserted mid-operation, including mid-auto-repeat, SHALL abort the operation with no trailing pulse.
REQ-038 A button held through reset release SHALL produce exactly one press event, DEBOUNCE_CYCLES+3 cycles after release.

Structure
REQ-039 The state encoding and its 4-bit width SHALL live in the shared package watch_pkg.
REQ-040 The parameter defaults SHALL also live in watch_pkg.
REQ-041 A sub-module btn_cond SHALL contain the synchroniser, debounce, edge detector and hold/repeat counters, and SHALL be instantiated once per button.
REQ-042 The hold/repeat counters SHALL be used only for the inc and dec instances.

Verification (DEBOUNCE_CYCLES=2, HOLD_CYCLES=8, REPEAT_CYCLES=3)
REQ-043 Reset release, then mode -> SW_SHOW_STOPPED after 5 cycles; inc -> SW_SHOW_RUNNING with run_stopwatch=1; inc -> SW_SHOW_STOPPED with run_stopwatch=0.
REQ-044 In SW_SHOW_STOPPED, dec -> SW_RESET with reset_stopwatch=1 for exactly 1 cycle, then SW_SHOW_STOPPED.
REQ-045 Starting in SW_HIDE_RUNNING, set -> SET_H with run_time=0 and run_stopwatch=1; set -> SET_M; set -> ALM_H with alarm_sel=1 and run_time=1; set -> ALM_M; set -> SW_HIDE_RUNNING.
REQ-046 In SET_M, hold inc for 20 cycles -> inc_m pulses at relative cycles 0, 8, 11, 14 and 17 (5 total), with no pulse after release.
REQ-047 In SET_H, press inc and dec together -> no pulses; then mode -> return to the saved state.
REQ-048 Within the DEBOUNCE_CYCLES window, a 1-cycle glitch on btn_mode -> no state change.
REQ-049 Assert reset_n low mid-auto-repeat -> all outputs reach reset values before the next clk edge.
